// File: rtl/stopwatch_bcd_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM state encoding and digit width.
package stopwatch_bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSED = 3'd2,
    ST_LAP    = 3'd3,
    ST_OVF    = 3'd4
  } state_t;

endpackage

// File: rtl/stopwatch_bcd_bcd_digit.sv
// Single mod-10 BCD digit; carry_out is combinational so a cascade advances on one edge.
module bcd_digit
  import stopwatch_bcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc_in,
  output logic               carry_out,
  output logic [DIGIT_W-1:0] q
);

  localparam logic [DIGIT_W-1:0] NINE = DIGIT_W'(9);

  assign carry_out = inc_in & (q == NINE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc_in) begin
      q <= (q == NINE) ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// SS.hh stopwatch counting rising edges of the ms pulse, with start/stop/clear/lap control.
//   state  | meaning
//   IDLE   | zeroed, waiting for start
//   RUN    | counting, display follows live value
//   PAUSED | counter and prescaler held
//   LAP    | counting, display frozen
//   OVF    | saturated at SEC_MAX.99, only clear leaves
module stopwatch_bcd
  import stopwatch_bcd_pkg::*;
#(
  parameter int MS_PER_HUND = 10,
  parameter int SEC_MAX     = 59
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ms_pulse,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               lap,
  output logic               run,
  output logic [DIGIT_W-1:0] d3,
  output logic [DIGIT_W-1:0] d2,
  output logic [DIGIT_W-1:0] d1,
  output logic [DIGIT_W-1:0] d0,
  output logic               lap_frozen,
  output logic               overflow
);

  localparam logic [3:0]         PRE_LAST = 4'(MS_PER_HUND - 1);
  localparam logic [DIGIT_W-1:0] SEC_T    = DIGIT_W'(SEC_MAX / 10);
  localparam logic [DIGIT_W-1:0] SEC_O    = DIGIT_W'(SEC_MAX % 10);
  localparam logic [DIGIT_W-1:0] NINE     = DIGIT_W'(9);

  state_t             state;
  logic               ms_q;
  logic [3:0]         pre;
  logic [DIGIT_W-1:0] q0, q1, q2, q3;
  logic               c0, c1, c2, c3_unused;
  logic               counting, tick, tick_act, hund_inc, at_max, sat_hit, inc0;

  assign counting = (state == ST_RUN) || (state == ST_LAP);
  assign tick     = ms_pulse & ~ms_q;
  assign tick_act = tick & counting & ~clear;
  assign hund_inc = tick_act & (pre == PRE_LAST);
  assign at_max   = (q3 == SEC_T) && (q2 == SEC_O) && (q1 == NINE) && (q0 == NINE);
  assign sat_hit  = hund_inc & at_max;
  // Saturation blocks the increment so the cascade never wraps past SEC_MAX.99.
  assign inc0     = hund_inc & ~at_max;

  bcd_digit u_d0 (.clk(clk), .rst_n(rst_n), .clr(clear), .inc_in(inc0), .carry_out(c0), .q(q0));
  bcd_digit u_d1 (.clk(clk), .rst_n(rst_n), .clr(clear), .inc_in(c0),   .carry_out(c1), .q(q1));
  bcd_digit u_d2 (.clk(clk), .rst_n(rst_n), .clr(clear), .inc_in(c1),   .carry_out(c2), .q(q2));
  bcd_digit u_d3 (.clk(clk), .rst_n(rst_n), .clr(clear), .inc_in(c2),   .carry_out(c3_unused), .q(q3));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_q <= 1'b0;
      pre  <= '0;
    end else begin
      ms_q <= ms_pulse;
      if (clear) begin
        pre <= '0;
      end else if (tick_act) begin
        pre <= (pre == PRE_LAST) ? 4'd0 : pre + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      run        <= 1'b0;
      lap_frozen <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      run        <= 1'b0;
      lap_frozen <= 1'b0;
      overflow   <= 1'b0;
    end else if (sat_hit) begin
      state      <= ST_OVF;
      run        <= 1'b0;
      lap_frozen <= 1'b0;
      overflow   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_RUN;
          run   <= 1'b1;
        end
        ST_RUN: if (stop) begin
          state <= ST_PAUSED;
          run   <= 1'b0;
        end else if (!start && lap) begin
          state      <= ST_LAP;
          lap_frozen <= 1'b1;
        end
        ST_LAP: if (stop) begin
          state      <= ST_PAUSED;
          run        <= 1'b0;
          lap_frozen <= 1'b0;
        end else if (!start && lap) begin
          state      <= ST_RUN;
          lap_frozen <= 1'b0;
        end
        ST_PAUSED: if (!stop && start) begin
          state <= ST_RUN;
          run   <= 1'b1;
        end
        default: state <= state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {d3, d2, d1, d0} <= '0;
    end else if (clear) begin
      {d3, d2, d1, d0} <= '0;
    end else if (state != ST_LAP) begin
      {d3, d2, d1, d0} <= {q3, q2, q1, q0};
    end
  end

endmodule
